oam_dma_ctrl: RTL

Sprite-DMA controller and CPU/DMA bus arbiter for the NES memory subsystem. It sits between the 6502 core (reference or DUV) and the mem top. A CPU write to $4014 starts a transfer. The controller then halts the CPU through RDY, takes ownership of the memory bus, and copies the 256-byte page $XX00–$XXFF to the OAM data port ($2004) in alternating read/write cycles. It preserves 6502 RDY semantics and NES get/put cycle alignment.

---
 rtl/oam_dma_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/oam_dma_ctrl.sv
// -----------------------------------------------------------------------------
// oam_dma_ctrl
//
// Sprite-DMA controller and CPU/DMA bus arbiter. A CPU write to TRIG_ADDR
// starts a transfer. The controller halts the 6502 through RDY, takes the
// memory bus, and copies page {page,8'h00}..{page,8'hFF} to OAM_ADDR. It does
// this in alternating read (get) and write (put) cycles.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   cpu_addr_i/_dout_i/_we_i   CPU bus cycle (address, write data, write flag)
//   cpu_rdy_o         6502 RDY, low while a transfer is pending or running
//   mem_addr_o/_dout_o/_we_o   bus towards the memory top (CPU or DMA owned)
//   mem_din_i         memory read data, combinational on mem_addr_o
//   dma_busy_o        high from the cycle after the trigger until completion
// -----------------------------------------------------------------------------
module oam_dma_ctrl #(
  parameter logic [15:0] TRIG_ADDR = 16'h4014,
  parameter logic [15:0] OAM_ADDR  = 16'h2004
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cpu_addr_i,
  input  logic [7:0]  cpu_dout_i,
  input  logic        cpu_we_i,
  output logic        cpu_rdy_o,
  output logic [15:0] mem_addr_o,
  output logic [7:0]  mem_dout_o,
  output logic        mem_we_o,
  input  logic [7:0]  mem_din_i,
  output logic        dma_busy_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_READ,
    S_WRITE
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] page_q, page_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] data_q, data_d;
  logic       get_cyc_q, get_cyc_d;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its _d input regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      page_q    <= 8'h00;
      idx_q     <= 8'h00;
      data_q    <= 8'h00;
      get_cyc_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      page_q    <= page_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      get_cyc_q <= get_cyc_d;
    end
  end

  // Next-state logic.
  // NOTE: every signal assigned here gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_d   = state_q;
    page_d    = page_q;
    idx_d     = idx_q;
    data_d    = data_q;
    // Get/put parity runs freely, independent of bus activity.
    get_cyc_d = ~get_cyc_q;

    case (state_q)
      S_IDLE: begin
        if (cpu_we_i && (cpu_addr_i == TRIG_ADDR)) begin
          page_d  = cpu_dout_i;
          idx_d   = 8'h00;
          state_d = S_HALT;
        end
      end
      S_HALT: begin
        // The 6502 keeps running through write cycles. The first read is the
        // halt cycle. A READ must land on a get cycle. The next cycle is a get
        // cycle exactly when this one is a put cycle.
        if (!cpu_we_i) begin
          state_d = get_cyc_q ? S_ALIGN : S_READ;
        end
      end
      S_ALIGN: begin
        state_d = S_READ;
      end
      S_READ: begin
        data_d  = mem_din_i;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        // idx wraps inside the byte, so page $FF never spills into $0000.
        idx_d   = idx_q + 8'h01;
        state_d = (idx_q == 8'hFF) ? S_IDLE : S_READ;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs: RDY/busy come straight from the state register. The bus is
  // owned by the DMA only in READ and WRITE and is passed through otherwise.
  always_comb begin
    cpu_rdy_o  = (state_q == S_IDLE);
    dma_busy_o = (state_q != S_IDLE);
    mem_addr_o = cpu_addr_i;
    mem_dout_o = cpu_dout_i;
    mem_we_o   = cpu_we_i;
    case (state_q)
      S_READ: begin
        mem_addr_o = {page_q, idx_q};
        mem_dout_o = data_q;
        mem_we_o   = 1'b0;
      end
      S_WRITE: begin
        mem_addr_o = OAM_ADDR;
        mem_dout_o = data_q;
        mem_we_o   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
